// File: rtl/cpu_pkg.sv
// Shared decode constants for the ID stage: opcodes, EXE commands, branch types,
// instruction field positions and the decoder output record.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned FIELD_W  = 5;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned DEC_CMD_W = 4;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned DEST_MSB = 25;
    localparam int unsigned DEST_LSB = 21;
    localparam int unsigned SRC1_MSB = 20;
    localparam int unsigned SRC1_LSB = 16;
    localparam int unsigned SRC2_MSB = 15;
    localparam int unsigned SRC2_LSB = 11;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'd3;
    localparam logic [OPC_W-1:0] OP_AND  = 6'd5;
    localparam logic [OPC_W-1:0] OP_OR   = 6'd6;
    localparam logic [OPC_W-1:0] OP_NOR  = 6'd7;
    localparam logic [OPC_W-1:0] OP_XOR  = 6'd8;
    localparam logic [OPC_W-1:0] OP_SLA  = 6'd9;
    localparam logic [OPC_W-1:0] OP_SLL  = 6'd10;
    localparam logic [OPC_W-1:0] OP_SRA  = 6'd11;
    localparam logic [OPC_W-1:0] OP_SRL  = 6'd12;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'd32;
    localparam logic [OPC_W-1:0] OP_SUBI = 6'd33;
    localparam logic [OPC_W-1:0] OP_LD   = 6'd36;
    localparam logic [OPC_W-1:0] OP_ST   = 6'd37;
    localparam logic [OPC_W-1:0] OP_BEZ  = 6'd40;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'd41;
    localparam logic [OPC_W-1:0] OP_JMP  = 6'd42;

    localparam logic [DEC_CMD_W-1:0] CMD_ADD = 4'b0000;
    localparam logic [DEC_CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [DEC_CMD_W-1:0] CMD_AND = 4'b0100;
    localparam logic [DEC_CMD_W-1:0] CMD_OR  = 4'b0101;
    localparam logic [DEC_CMD_W-1:0] CMD_NOR = 4'b0110;
    localparam logic [DEC_CMD_W-1:0] CMD_XOR = 4'b0111;
    localparam logic [DEC_CMD_W-1:0] CMD_SHL = 4'b1000;
    localparam logic [DEC_CMD_W-1:0] CMD_SRA = 4'b1001;
    localparam logic [DEC_CMD_W-1:0] CMD_SRL = 4'b1010;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef struct packed {
        logic [DEC_CMD_W-1:0] exe_cmd;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 wb_en;
        br_type_e             br_type;
        logic                 is_imm;
        logic                 uses_src1;
        logic                 uses_src2;
        logic                 src2_from_dest;
    } dec_t;

endpackage

// File: rtl/id_stage_pl_if.sv
// Bundle between IF/ID, register file, EXE and the ID stage. ID_STAGE_FWD_EN adds
// the registered source-address outputs for a downstream forwarding unit.
interface id_stage_pl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CMD_W  = 4
);
    logic              instr_valid;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              stall;
    logic              flush;
    logic [REG_AW-1:0] exe_dest;
    logic              exe_wb_en;
    logic              exe_mem_r_en;

    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              id_ready;
    logic              hazard;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] reg2_out;
    logic [CMD_W-1:0]  exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic [1:0]        br_type;
`ifdef ID_STAGE_FWD_EN
    logic [REG_AW-1:0] ex_src1;
    logic [REG_AW-1:0] ex_src2;
`endif

    modport master (
        output instr_valid, instruction, pc_in, reg1, reg2, stall, flush,
               exe_dest, exe_wb_en, exe_mem_r_en,
        input  src1, src2, id_ready, hazard,
               ex_valid, ex_pc, dest, val1, val2, reg2_out, exe_cmd,
               mem_r_en, mem_w_en, wb_en, br_type
`ifdef ID_STAGE_FWD_EN
        , input ex_src1, ex_src2
`endif
    );

    modport slave (
        input  instr_valid, instruction, pc_in, reg1, reg2, stall, flush,
               exe_dest, exe_wb_en, exe_mem_r_en,
        output src1, src2, id_ready, hazard,
               ex_valid, ex_pc, dest, val1, val2, reg2_out, exe_cmd,
               mem_r_en, mem_w_en, wb_en, br_type
`ifdef ID_STAGE_FWD_EN
        , output ex_src1, ex_src2
`endif
    );

endinterface

// File: rtl/id_decoder.sv
// Combinational opcode decoder: EXE command, enables, branch type and operand usage.
module id_decoder
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output dec_t             dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
                dec_o.wb_en     = 1'b1;
                dec_o.uses_src1 = 1'b1;
                dec_o.uses_src2 = 1'b1;
                case (opcode_i)
                    OP_SUB:         dec_o.exe_cmd = CMD_SUB;
                    OP_AND:         dec_o.exe_cmd = CMD_AND;
                    OP_OR:          dec_o.exe_cmd = CMD_OR;
                    OP_NOR:         dec_o.exe_cmd = CMD_NOR;
                    OP_XOR:         dec_o.exe_cmd = CMD_XOR;
                    OP_SLA, OP_SLL: dec_o.exe_cmd = CMD_SHL;
                    OP_SRA:         dec_o.exe_cmd = CMD_SRA;
                    OP_SRL:         dec_o.exe_cmd = CMD_SRL;
                    default:        dec_o.exe_cmd = CMD_ADD;
                endcase
            end
            OP_ADDI, OP_SUBI, OP_LD: begin
                dec_o.exe_cmd   = (opcode_i == OP_SUBI) ? CMD_SUB : CMD_ADD;
                dec_o.wb_en     = 1'b1;
                dec_o.mem_r_en  = (opcode_i == OP_LD);
                dec_o.is_imm    = 1'b1;
                dec_o.uses_src1 = 1'b1;
            end
            OP_ST: begin
                dec_o.mem_w_en       = 1'b1;
                dec_o.is_imm         = 1'b1;
                dec_o.uses_src1      = 1'b1;
                dec_o.uses_src2      = 1'b1;
                dec_o.src2_from_dest = 1'b1;
            end
            OP_BEZ: begin
                dec_o.br_type   = BR_BEZ;
                dec_o.is_imm    = 1'b1;
                dec_o.uses_src1 = 1'b1;
            end
            OP_BNE: begin
                dec_o.br_type        = BR_BNE;
                dec_o.is_imm         = 1'b1;
                dec_o.uses_src1      = 1'b1;
                dec_o.uses_src2      = 1'b1;
                dec_o.src2_from_dest = 1'b1;
            end
            OP_JMP: begin
                dec_o.br_type = BR_JMP;
                dec_o.is_imm  = 1'b1;
            end
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_pl.sv
// Registered instruction-decode stage: decode, operand select, RAW hazard detect and
// the ID/EX register. ID_STAGE_FWD_EN selects load-use-only hazards plus source outputs.
module id_stage_pl
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CMD_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_pl_if.slave bus
);

    logic [OPC_W-1:0]   f_opc;
    logic [FIELD_W-1:0] f_dest;
    logic [FIELD_W-1:0] f_src1;
    logic [FIELD_W-1:0] f_src2;
    logic [IMM_W-1:0]   f_imm;
    dec_t               dec;

    assign f_opc  = bus.instruction[OPC_MSB:OPC_LSB];
    assign f_dest = bus.instruction[DEST_MSB:DEST_LSB];
    assign f_src1 = bus.instruction[SRC1_MSB:SRC1_LSB];
    assign f_src2 = bus.instruction[SRC2_MSB:SRC2_LSB];
    assign f_imm  = bus.instruction[IMM_MSB:IMM_LSB];

    id_decoder u_dec (
        .opcode_i (f_opc),
        .dec_o    (dec)
    );

    logic [REG_AW-1:0] src1_c;
    logic [REG_AW-1:0] src2_c;
    logic              exe_qual_c;
    logic              hazard_c;

    // ST and BNE compare against the register named in the dest field
    assign src1_c = REG_AW'(f_src1);
    assign src2_c = dec.src2_from_dest ? REG_AW'(f_dest) : REG_AW'(f_src2);

`ifdef ID_STAGE_FWD_EN
    assign exe_qual_c = bus.exe_mem_r_en;
`else
    assign exe_qual_c = bus.exe_wb_en;
`endif

    assign hazard_c = bus.instr_valid && (bus.exe_dest != '0) && exe_qual_c &&
                      ((dec.uses_src1 && (bus.exe_dest == src1_c)) ||
                       (dec.uses_src2 && (bus.exe_dest == src2_c)));

    assign bus.src1     = src1_c;
    assign bus.src2     = src2_c;
    assign bus.hazard   = hazard_c;
    assign bus.id_ready = !bus.stall && !hazard_c && !bus.flush;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_pc_q,    ex_pc_d;
    logic [REG_AW-1:0] dest_q,     dest_d;
    logic [DATA_W-1:0] val1_q,     val1_d;
    logic [DATA_W-1:0] val2_q,     val2_d;
    logic [DATA_W-1:0] reg2_out_q, reg2_out_d;
    logic [CMD_W-1:0]  exe_cmd_q,  exe_cmd_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              wb_en_q,    wb_en_d;
    logic [1:0]        br_type_q,  br_type_d;
`ifdef ID_STAGE_FWD_EN
    logic [REG_AW-1:0] ex_src1_q,  ex_src1_d;
    logic [REG_AW-1:0] ex_src2_q,  ex_src2_d;
`endif

    logic bubble_c;
    logic load_c;

    // flush beats stall; stall beats hazard
    assign bubble_c = bus.flush || (!bus.stall && hazard_c);
    assign load_c   = !bus.flush && !bus.stall && !hazard_c;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        dest_d     = dest_q;
        val1_d     = val1_q;
        val2_d     = val2_q;
        reg2_out_d = reg2_out_q;
        exe_cmd_d  = exe_cmd_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        wb_en_d    = wb_en_q;
        br_type_d  = br_type_q;
`ifdef ID_STAGE_FWD_EN
        ex_src1_d  = ex_src1_q;
        ex_src2_d  = ex_src2_q;
`endif
        if (bubble_c) begin
            ex_valid_d = 1'b0;
            ex_pc_d    = '0;
            dest_d     = '0;
            val1_d     = '0;
            val2_d     = '0;
            reg2_out_d = '0;
            exe_cmd_d  = '0;
            mem_r_en_d = 1'b0;
            mem_w_en_d = 1'b0;
            wb_en_d    = 1'b0;
            br_type_d  = BR_NONE;
`ifdef ID_STAGE_FWD_EN
            ex_src1_d  = '0;
            ex_src2_d  = '0;
`endif
        end else if (load_c) begin
            ex_valid_d = bus.instr_valid;
            ex_pc_d    = bus.pc_in;
            dest_d     = REG_AW'(f_dest);
            val1_d     = bus.reg1;
            val2_d     = dec.is_imm ? DATA_W'($signed(f_imm)) : bus.reg2;
            reg2_out_d = bus.reg2;
            exe_cmd_d  = CMD_W'(dec.exe_cmd);
            mem_r_en_d = dec.mem_r_en;
            mem_w_en_d = dec.mem_w_en;
            wb_en_d    = dec.wb_en && (f_dest != '0);
            br_type_d  = dec.br_type;
`ifdef ID_STAGE_FWD_EN
            ex_src1_d  = dec.uses_src1 ? src1_c : '0;
            ex_src2_d  = dec.uses_src2 ? src2_c : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            dest_q     <= '0;
            val1_q     <= '0;
            val2_q     <= '0;
            reg2_out_q <= '0;
            exe_cmd_q  <= '0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            wb_en_q    <= 1'b0;
            br_type_q  <= BR_NONE;
`ifdef ID_STAGE_FWD_EN
            ex_src1_q  <= '0;
            ex_src2_q  <= '0;
`endif
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            dest_q     <= dest_d;
            val1_q     <= val1_d;
            val2_q     <= val2_d;
            reg2_out_q <= reg2_out_d;
            exe_cmd_q  <= exe_cmd_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            wb_en_q    <= wb_en_d;
            br_type_q  <= br_type_d;
`ifdef ID_STAGE_FWD_EN
            ex_src1_q  <= ex_src1_d;
            ex_src2_q  <= ex_src2_d;
`endif
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc    = ex_pc_q;
    assign bus.dest     = dest_q;
    assign bus.val1     = val1_q;
    assign bus.val2     = val2_q;
    assign bus.reg2_out = reg2_out_q;
    assign bus.exe_cmd  = exe_cmd_q;
    assign bus.mem_r_en = mem_r_en_q;
    assign bus.mem_w_en = mem_w_en_q;
    assign bus.wb_en    = wb_en_q;
    assign bus.br_type  = br_type_q;
`ifdef ID_STAGE_FWD_EN
    assign bus.ex_src1  = ex_src1_q;
    assign bus.ex_src2  = ex_src2_q;
`endif

endmodule

// File: tb/tb_id_stage_pl.sv
// Directed self-checking bench for id_stage_pl; expectations adapt to ID_STAGE_FWD_EN.
module tb_id_stage_pl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    id_stage_pl_if #(.DATA_W(32), .REG_AW(5), .CMD_W(4)) bus ();

    id_stage_pl #(.DATA_W(32), .REG_AW(5), .CMD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    // advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] pc);
        bus.instr_valid = 1'b1;
        bus.instruction = ins;
        bus.reg1        = r1;
        bus.reg2        = r2;
        bus.pc_in       = pc;
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'd0);
        chk({tag, ".wb_en"},    32'(bus.wb_en),    32'd0);
        chk({tag, ".mem_r_en"}, 32'(bus.mem_r_en), 32'd0);
        chk({tag, ".mem_w_en"}, 32'(bus.mem_w_en), 32'd0);
        chk({tag, ".br_type"},  32'(bus.br_type),  32'd0);
        chk({tag, ".exe_cmd"},  32'(bus.exe_cmd),  32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.instr_valid  = 1'b0;
        bus.instruction  = '0;
        bus.pc_in        = '0;
        bus.reg1         = '0;
        bus.reg2         = '0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.exe_dest     = '0;
        bus.exe_wb_en    = 1'b0;
        bus.exe_mem_r_en = 1'b0;

        tick();
        chk_bubble("reset");
        chk("reset.dest", 32'(bus.dest), 32'd0);
        chk("reset.val1", bus.val1, 32'd0);
        chk("reset.ex_pc", bus.ex_pc, 32'd0);
        rst = 1'b0;

        // ADD r3,r1,r2
        issue(enc_r(6'd1, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 32'h100);
        chk("add.src1", 32'(bus.src1), 32'd1);
        chk("add.src2", 32'(bus.src2), 32'd2);
        chk("add.hazard", 32'(bus.hazard), 32'd0);
        chk("add.id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        chk("add.ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("add.dest", 32'(bus.dest), 32'd3);
        chk("add.val1", bus.val1, 32'd5);
        chk("add.val2", bus.val2, 32'd7);
        chk("add.exe_cmd", 32'(bus.exe_cmd), 32'd0);
        chk("add.wb_en", 32'(bus.wb_en), 32'd1);
        chk("add.ex_pc", bus.ex_pc, 32'h100);

        // ADDI r4,r1,-2
        issue(enc_i(6'd32, 5'd4, 5'd1, 16'hFFFE), 32'd9, 32'd11, 32'h101);
        tick();
        chk("addi.val2", bus.val2, 32'hFFFF_FFFE);
        chk("addi.exe_cmd", 32'(bus.exe_cmd), 32'd0);
        chk("addi.mem_r_en", 32'(bus.mem_r_en), 32'd0);
        chk("addi.wb_en", 32'(bus.wb_en), 32'd1);

        // SUB and SRA commands
        issue(enc_r(6'd3, 5'd7, 5'd1, 5'd2), 32'd1, 32'd2, 32'h102);
        tick();
        chk("sub.exe_cmd", 32'(bus.exe_cmd), 32'b0010);
        issue(enc_r(6'd11, 5'd7, 5'd1, 5'd2), 32'd1, 32'd2, 32'h103);
        tick();
        chk("sra.exe_cmd", 32'(bus.exe_cmd), 32'b1001);

        // ST r9 -> [r1+4]: src2 comes from dest field
        issue(enc_i(6'd37, 5'd9, 5'd1, 16'd4), 32'd20, 32'hABCD, 32'h104);
        chk("st.src2", 32'(bus.src2), 32'd9);
        tick();
        chk("st.mem_w_en", 32'(bus.mem_w_en), 32'd1);
        chk("st.wb_en", 32'(bus.wb_en), 32'd0);
        chk("st.val2", bus.val2, 32'd4);
        chk("st.reg2_out", bus.reg2_out, 32'hABCD);

        // LD r5,[r1+8]
        issue(enc_i(6'd36, 5'd5, 5'd1, 16'd8), 32'd0, 32'd0, 32'h105);
        tick();
        chk("ld.mem_r_en", 32'(bus.mem_r_en), 32'd1);
        chk("ld.wb_en", 32'(bus.wb_en), 32'd1);

        // BNE / JMP branch types
        issue(enc_i(6'd41, 5'd6, 5'd1, 16'd3), 32'd0, 32'd0, 32'h106);
        chk("bne.src2", 32'(bus.src2), 32'd6);
        tick();
        chk("bne.br_type", 32'(bus.br_type), 32'd2);
        chk("bne.wb_en", 32'(bus.wb_en), 32'd0);
        issue(enc_i(6'd42, 5'd0, 5'd0, 16'd16), 32'd0, 32'd0, 32'h107);
        tick();
        chk("jmp.br_type", 32'(bus.br_type), 32'd3);

        // unlisted opcode is a NOP
        issue(enc_r(6'd63, 5'd3, 5'd1, 5'd2), 32'd1, 32'd2, 32'h108);
        tick();
        chk("nop.ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("nop.wb_en", 32'(bus.wb_en), 32'd0);
        chk("nop.exe_cmd", 32'(bus.exe_cmd), 32'd0);

        // load-use: LD r5 in EXE, ADD r6,r5,r2 in ID
        bus.exe_dest = 5'd5; bus.exe_mem_r_en = 1'b1; bus.exe_wb_en = 1'b1;
        issue(enc_r(6'd1, 5'd6, 5'd5, 5'd2), 32'd40, 32'd2, 32'h109);
        chk("lu.hazard", 32'(bus.hazard), 32'd1);
        chk("lu.id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        chk_bubble("lu.bubble");
        bus.exe_dest = 5'd0; bus.exe_mem_r_en = 1'b0; bus.exe_wb_en = 1'b0;
        #1;
        chk("lu.hazard_drop", 32'(bus.hazard), 32'd0);
        tick();
        chk("lu.ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu.dest", 32'(bus.dest), 32'd6);
        chk("lu.val1", bus.val1, 32'd40);

        // stall hold for 3 cycles after loading XOR r8
        issue(enc_r(6'd8, 5'd8, 5'd1, 5'd2), 32'd3, 32'd5, 32'h10A);
        tick();
        bus.stall = 1'b1;
        issue(enc_r(6'd3, 5'd12, 5'd1, 5'd2), 32'd99, 32'd98, 32'h10B);
        chk("stall.id_ready", 32'(bus.id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.dest", 32'(bus.dest), 32'd8);
            chk("stall.exe_cmd", 32'(bus.exe_cmd), 32'b0111);
            chk("stall.val1", bus.val1, 32'd3);
            chk("stall.ex_valid", 32'(bus.ex_valid), 32'd1);
        end

        // flush and stall together
        bus.flush = 1'b1;
        #1;
        chk("flush.id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        chk_bubble("flush");
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // ADD r0,r1,r2 never writes back
        issue(enc_r(6'd1, 5'd0, 5'd1, 5'd2), 32'd1, 32'd2, 32'h10C);
        tick();
        chk("r0.ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("r0.wb_en", 32'(bus.wb_en), 32'd0);

        // non-load writer in EXE
        bus.exe_dest = 5'd1; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b0;
        issue(enc_r(6'd1, 5'd2, 5'd1, 5'd3), 32'd1, 32'd2, 32'h10D);
`ifdef ID_STAGE_FWD_EN
        chk("wr.hazard", 32'(bus.hazard), 32'd0);
        tick();
        chk("wr.ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("wr.ex_src1", 32'(bus.ex_src1), 32'd1);
        chk("wr.ex_src2", 32'(bus.ex_src2), 32'd3);
`else
        chk("wr.hazard", 32'(bus.hazard), 32'd1);
        chk("wr.id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        chk("wr.ex_valid", 32'(bus.ex_valid), 32'd0);
`endif
        // invalid instruction never flags a hazard
        bus.instr_valid = 1'b0;
        #1;
        chk("inv.hazard", 32'(bus.hazard), 32'd0);
        tick();
        chk("inv.ex_valid", 32'(bus.ex_valid), 32'd0);
        bus.exe_dest = 5'd0; bus.exe_wb_en = 1'b0;

        // reset while stalled overrides held contents
        issue(enc_r(6'd1, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 32'h10E);
        tick();
        chk("pre_rst.ex_valid", 32'(bus.ex_valid), 32'd1);
        bus.stall = 1'b1;
        rst = 1'b1;
        tick();
        chk_bubble("rst_stall");
        chk("rst_stall.dest", 32'(bus.dest), 32'd0);
        chk("rst_stall.val1", bus.val1, 32'd0);
        chk("rst_stall.val2", bus.val2, 32'd0);
        chk("rst_stall.ex_pc", bus.ex_pc, 32'd0);
        rst = 1'b0;
        bus.stall = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
